// File: rtl/lzc_norm_pkg.sv
// Shared widths, pipeline stage record and error sentinel for the LZC normaliser.
package lzc_norm_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  typedef struct packed {
    logic              vld;
    logic              zero;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
  } stage_t;

  localparam logic [DATA_W-1:0] ERR_SENTINEL = 32'hFFFF_FFFF;

  // Build the S1 input record from the operand and the LZC word {.., v, z[4:0]}.
  function automatic stage_t stage_entry(input logic vld, input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b);
    stage_t s;
    s.vld  = vld;
    s.zero = b[CNT_W];
    s.data = b[CNT_W] ? '0 : a;
    s.cnt  = b[CNT_W-1:0];
    return s;
  endfunction

endpackage

// File: rtl/lzc_norm_shift_stage.sv
// One registered barrel-shifter stage: shifts left by SHIFT when its count bit is set.
// Loads its predecessor on adv, holds otherwise.
module lzc_norm_shift_stage
  import lzc_norm_pkg::*;
#(
  parameter int SHIFT = 16
) (
  input  logic   clock,
  input  logic   resetn,
  input  logic   adv,
  input  stage_t din,
  output stage_t dout
);

  localparam int BIT = $clog2(SHIFT);

  stage_t nxt;

  always_comb begin
    nxt = din;
    if (din.cnt[BIT]) nxt.data = din.data << SHIFT;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dout <= '0;
    end else if (adv) begin
      dout <= nxt;
    end
  end

endmodule

// File: rtl/lzc32_norm_uint_module.sv
// Five-stage pipelined left-normaliser driven by an LZC result word; whole pipe stalls when S5 is held.
// LZC_NORM_CHECK_EN: replace results whose MSB is not set (count inconsistent) with ERR_SENTINEL.
module lzc32_norm_uint_module
  import lzc_norm_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              ivalid,
  input  logic              iready,
  output logic              ovalid,
  output logic              oready,
  input  logic [DATA_W-1:0] datain_a,
  input  logic [DATA_W-1:0] datain_b,
  output logic [DATA_W-1:0] dataout
);

  stage_t pipe [0:5];
  logic   adv;

  assign adv     = ~pipe[5].vld | iready;
  assign oready  = adv;
  assign pipe[0] = stage_entry(ivalid & adv, datain_a, datain_b);

  // Shift amounts 16, 8, 4, 2, 1 consume count bits 4 down to 0.
  for (genvar i = 0; i < CNT_W; i++) begin : g_stage
    lzc_norm_shift_stage #(
      .SHIFT((DATA_W / 2) >> i)
    ) u_stage (
      .clock  (clock),
      .resetn (resetn),
      .adv    (adv),
      .din    (pipe[i]),
      .dout   (pipe[i+1])
    );
  end

  assign ovalid = pipe[5].vld;

`ifdef LZC_NORM_CHECK_EN
  assign dataout = (pipe[5].vld && !pipe[5].zero && !pipe[5].data[DATA_W-1]) ? ERR_SENTINEL
                                                                             : pipe[5].data;
`else
  assign dataout = pipe[5].data;
`endif

  logic unused_tail;
  assign unused_tail = ^{datain_b[DATA_W-1:CNT_W+1], pipe[5].cnt, pipe[5].zero};

endmodule

// File: tb/tb_lzc32_norm_uint_module.sv
// Scoreboard bench for lzc32_norm_uint_module: driver pushes expected results, monitor pops on handshake.
module tb_lzc32_norm_uint_module;

  logic        clock = 1'b0;
  logic        resetn;
  logic        ivalid;
  logic        iready;
  logic        ovalid;
  logic        oready;
  logic [31:0] datain_a;
  logic [31:0] datain_b;
  logic [31:0] dataout;

  lzc32_norm_uint_module dut (
    .clock    (clock),
    .resetn   (resetn),
    .ivalid   (ivalid),
    .iready   (iready),
    .ovalid   (ovalid),
    .oready   (oready),
    .datain_a (datain_a),
    .datain_b (datain_b),
    .dataout  (dataout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    int          c;
    bit          lat;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_bad = 0;
  bit          lat_en = 1'b1;
  bit          stalled = 1'b0;
  logic [31:0] held;

`ifdef LZC_NORM_CHECK_EN
  localparam logic [31:0] BADZ_EXP = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] BADZ_EXP = 32'h00F0_0000;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int w = 0;
    @(negedge clock);
    ivalid   = 1'b1;
    datain_a = a;
    datain_b = b;
    #1;
    while (!oready && w < 50) begin
      @(negedge clock);
      #1;
      w++;
    end
    if (!oready) begin
      n_chk++;
      n_bad++;
      $display("FAIL send_timeout: oready stuck at %b, wanted 1", oready);
    end else begin
      q.push_back('{d: exp, c: cyc + 5, lat: lat_en});
    end
    @(posedge clock);
    #1;
    ivalid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 100) begin
      @(negedge clock);
      w++;
    end
    n_chk++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d results outstanding, wanted 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  // Monitor: every output handshake retires the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (resetn && ovalid) begin
        if (stalled) chk("held_data", dataout, held);
        if (!iready) begin
          chk("oready_stall", {31'b0, oready}, 32'h0);
          stalled = 1'b1;
          held    = dataout;
        end else begin
          stalled = 1'b0;
          if (q.size() == 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL unexpected_output: got %h want none", dataout);
          end else begin
            e = q.pop_front();
            chk("dataout", dataout, e.d);
            if (e.lat) chk("latency", 32'(cyc), 32'(e.c));
          end
        end
      end
    end
  end

  initial begin
    resetn   = 1'b0;
    ivalid   = 1'b0;
    iready   = 1'b1;
    datain_a = '0;
    datain_b = '0;
    #12;
    chk("rst_ovalid", {31'b0, ovalid}, 32'h0);
    chk("rst_dataout", dataout, 32'h0);
    chk("rst_oready", {31'b0, oready}, 32'h1);
    @(negedge clock);
    resetn = 1'b1;

    // Single items, ignored upper LZC bits, v forcing zero, truncation.
    send(32'h0000_0001, 32'h0000_001F, 32'h8000_0000);
    send(32'h0000_0000, 32'h0000_0020, 32'h0000_0000);
    send(32'h1234_5678, 32'hFFFF_FFC3, 32'h91A2_B3C0);
    send(32'hDEAD_BEEF, 32'h0000_0020, 32'h0000_0000);
    send(32'h0000_ABCD, 32'h0000_0010, 32'hABCD_0000);
    send(32'hFFFF_FFFF, 32'h0000_0004, 32'hFFFF_FFF0);
    drain();

    for (int k = 0; k < 8; k++) send(32'h1 << k, 32'(31 - k), 32'h8000_0000);
    drain();

    // Backpressure window over a six-item stream.
    lat_en = 1'b0;
    fork
      for (int k = 0; k < 6; k++) send(32'h8000_0000 | 32'(k), 32'h0, 32'h8000_0000 | 32'(k));
      begin
        repeat (7) @(negedge clock);
        iready = 1'b0;
        repeat (4) @(negedge clock);
        iready = 1'b1;
      end
    join
    drain();
    lat_en = 1'b1;

    // Reset with three items in flight.
    for (int k = 0; k < 3; k++) send(32'h0000_0100, 32'h0000_0017, 32'h8000_0000);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("midrst_ovalid", {31'b0, ovalid}, 32'h0);
    chk("midrst_dataout", dataout, 32'h0);
    q.delete();
    stalled = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    send(32'h0000_0003, 32'h0000_001E, 32'hC000_0000);
    drain();

    send(32'h0000_00F0, 32'h0000_0010, BADZ_EXP);
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
